// File: rtl/kit_pkg.sv
// Shared KIT definitions: shift direction encoding and counter width helper.
package kit_pkg;

  typedef enum logic {
    SHIFT_LEFT  = 1'b0,
    SHIFT_RIGHT = 1'b1
  } shift_dir_t;

  // Bits needed to hold a count of 0..width inclusive.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/dffe_shiftreg_sat_counter.sv
// Enabled up-counter with synchronous clear that saturates at MAX; done flags cnt == MAX.
module sat_counter #(
  parameter int unsigned MAX = 8,
  parameter int          W   = $clog2(MAX + 1)
) (
  input  logic         clk,
  input  logic         clrn,
  input  logic         en,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         done
);

  localparam logic [W-1:0] MAX_C = W'(MAX);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en) begin
      if (clr)                        cnt_d = '0;
      else if (inc && cnt_q != MAX_C) cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  // done is derived from the registered count, so it moves only with cnt.
  assign cnt  = cnt_q;
  assign done = (cnt_q == MAX_C);

endmodule

// File: rtl/dffe_shiftreg.sv
// WIDTH-bit enabled register with sync clear/set, parallel load and
// bidirectional serial shift; counts shifts since the last load/clear/set.
module dffe_shiftreg
  import kit_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter logic [WIDTH-1:0] SET_VAL   = '1
) (
  input  logic                           clk,
  input  logic                           clrn,
  input  logic                           en,
  input  logic                           sclr,
  input  logic                           sset,
  input  logic                           load,
  input  logic                           shift,
  input  logic                           dir,
  input  logic [WIDTH-1:0]               data,
  input  logic                           shiftin,
  output logic [WIDTH-1:0]               q,
  output logic                           shiftout,
  output logic [cnt_width(WIDTH)-1:0]    cnt,
  output logic                           done
);

  localparam int CW = cnt_width(WIDTH);

  logic [WIDTH-1:0] q_q, q_d;
  shift_dir_t       dir_s;

  assign dir_s = shift_dir_t'(dir);

  // data is only selected when load wins, so an undriven bus cannot leak into q.
  always_comb begin
    q_d = q_q;
    if (en) begin
      if (sclr)                         q_d = '0;
      else if (sset)                    q_d = SET_VAL;
      else if (load)                    q_d = data;
      else if (shift) begin
        if (dir_s == SHIFT_RIGHT)       q_d = {shiftin, q_q[WIDTH-1:1]};
        else                            q_d = {q_q[WIDTH-2:0], shiftin};
      end
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) q_q <= RESET_VAL;
    else       q_q <= q_d;
  end

  sat_counter #(
    .MAX (WIDTH),
    .W   (CW)
  ) u_cnt (
    .clk  (clk),
    .clrn (clrn),
    .en   (en),
    .clr  (sclr | sset | load),
    .inc  (shift),
    .cnt  (cnt),
    .done (done)
  );

  assign q        = q_q;
  assign shiftout = (dir_s == SHIFT_RIGHT) ? q_q[0] : q_q[WIDTH-1];

endmodule

// File: tb/tb_dffe_shiftreg.sv
// Vector table plus scoreboard queue for dffe_shiftreg (WIDTH=8), with hand sequences for reset/dir corners.
module tb_dffe_shiftreg;

  localparam int W  = 8;
  localparam int CW = 4;

  logic         clk = 1'b0;
  logic         clrn, en, sclr, sset, load, shift, dir, shiftin;
  logic [W-1:0] data;
  logic [W-1:0] q;
  logic         shiftout, done;
  logic [CW-1:0] cnt;

  dffe_shiftreg #(.WIDTH(W), .RESET_VAL(8'h00), .SET_VAL(8'hFF)) dut (
    .clk(clk), .clrn(clrn), .en(en), .sclr(sclr), .sset(sset), .load(load),
    .shift(shift), .dir(dir), .data(data), .shiftin(shiftin),
    .q(q), .shiftout(shiftout), .cnt(cnt), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         en, sclr, sset, load, shift, dir, si;
    logic [W-1:0] data;
    logic [W-1:0] eq;
    logic [CW-1:0] ecnt;
    logic         edone, eso;
  } vec_t;

  typedef struct {
    string         name;
    logic [W-1:0]  eq;
    logic [CW-1:0] ecnt;
    logic          edone, eso;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic vec_t mk(input logic e, sc, ss, ld, sh, d, si,
                              input logic [W-1:0] dat, eq,
                              input int ec, input logic ed, eso);
    vec_t v;
    v.en = e; v.sclr = sc; v.sset = ss; v.load = ld; v.shift = sh; v.dir = d;
    v.si = si; v.data = dat; v.eq = eq; v.ecnt = CW'(ec); v.edone = ed; v.eso = eso;
    return v;
  endfunction

  task automatic check(input string name, input logic [W-1:0] eq,
                       input logic [CW-1:0] ec, input logic ed, input logic eso);
    n_cmp++;
    if (q !== eq || cnt !== ec || done !== ed || shiftout !== eso) begin
      n_bad++;
      $display("FAIL %s: got q=%h cnt=%0d done=%b so=%b, want q=%h cnt=%0d done=%b so=%b",
               name, q, cnt, done, shiftout, eq, ec, ed, eso);
    end
  endtask

  // Drive one vector, queue its expectation, compare after the edge.
  task automatic apply(input string name, input vec_t v);
    exp_t e;
    en = v.en; sclr = v.sclr; sset = v.sset; load = v.load; shift = v.shift;
    dir = v.dir; shiftin = v.si; data = v.data;
    e.name = name; e.eq = v.eq; e.ecnt = v.ecnt; e.edone = v.edone; e.eso = v.eso;
    sb.push_back(e);
    @(posedge clk); #1;
    if (sb.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL scoreboard: got empty queue, want one entry");
    end else begin
      e = sb.pop_front();
      check(e.name, e.eq, e.ecnt, e.edone, e.eso);
    end
  endtask

  task automatic idle();
    en = 1'b1; sclr = 1'b0; sset = 1'b0; load = 1'b0; shift = 1'b0;
    dir = 1'b0; shiftin = 1'b0; data = '0;
  endtask

  initial begin
    // en sc ss ld sh dir si data   q      cnt done so
    tbl.push_back(mk(1,0,0,1,0,0,0, 8'hA5, 8'hA5, 0, 0, 1));
    tbl.push_back(mk(1,0,0,0,1,0,1, 8'h00, 8'h4B, 1, 0, 0));
    tbl.push_back(mk(1,0,0,0,1,0,1, 8'h00, 8'h97, 2, 0, 1));
    tbl.push_back(mk(1,0,0,0,1,0,1, 8'h00, 8'h2F, 3, 0, 0));
    tbl.push_back(mk(1,0,0,0,1,0,1, 8'h00, 8'h5F, 4, 0, 0));
    tbl.push_back(mk(1,0,0,0,1,0,1, 8'h00, 8'hBF, 5, 0, 1));
    tbl.push_back(mk(1,0,0,0,1,0,1, 8'h00, 8'h7F, 6, 0, 0));
    tbl.push_back(mk(1,0,0,0,1,0,1, 8'h00, 8'hFF, 7, 0, 1));
    tbl.push_back(mk(1,0,0,0,1,0,1, 8'h00, 8'hFF, 8, 1, 1));
    tbl.push_back(mk(1,0,0,0,1,0,0, 8'h00, 8'hFE, 8, 1, 1));
    tbl.push_back(mk(1,0,0,0,1,0,0, 8'h00, 8'hFC, 8, 1, 1));
    tbl.push_back(mk(1,0,0,1,1,0,0, 8'h3C, 8'h3C, 0, 0, 0));
    tbl.push_back(mk(1,0,0,1,0,1,0, 8'h81, 8'h81, 0, 0, 1));
    tbl.push_back(mk(1,0,0,0,1,1,0, 8'h00, 8'h40, 1, 0, 0));
    tbl.push_back(mk(1,0,0,0,1,1,0, 8'h00, 8'h20, 2, 0, 0));
    tbl.push_back(mk(1,0,0,0,1,1,0, 8'h00, 8'h10, 3, 0, 0));
    tbl.push_back(mk(1,1,1,1,1,0,1, 8'h3C, 8'h00, 0, 0, 0));
    tbl.push_back(mk(1,0,1,1,1,0,1, 8'h3C, 8'hFF, 0, 0, 1));
    tbl.push_back(mk(1,0,0,1,1,0,1, 8'h3C, 8'h3C, 0, 0, 0));
    tbl.push_back(mk(1,0,0,0,1,0,1, 8'h3C, 8'h79, 1, 0, 0));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(0,0,0,0,1,0,1, 8'h00, 8'h79, 1, 0, 0));
    tbl.push_back(mk(0,1,1,1,1,0,1, 8'h55, 8'h79, 1, 0, 0));
    tbl.push_back(mk(1,0,0,0,1,0,0, 8'h00, 8'hF2, 2, 0, 1));
    tbl.push_back(mk(1,0,0,0,1,0,0, 8'h00, 8'hE4, 3, 0, 1));

    idle();
    clrn = 1'b0;
    #2;
    check("reset_init", 8'h00, 0, 1'b0, 1'b0);
    @(posedge clk); #1;
    check("reset_held", 8'h00, 0, 1'b0, 1'b0);
    clrn = 1'b1;

    for (int i = 0; i < tbl.size(); i++)
      apply($sformatf("vec%0d", i), tbl[i]);

    // shiftout follows dir with no clock edge (q = E4).
    shift = 1'b0; dir = 1'b1; #1;
    check("dir_comb_right", 8'hE4, 3, 1'b0, 1'b0);
    dir = 1'b0; #1;
    check("dir_comb_left", 8'hE4, 3, 1'b0, 1'b1);

    // Alternating direction still counts every shift: E4 -L1-> C9 -R0-> 64.
    apply("mix_left",  mk(1,0,0,0,1,0,1, 8'h00, 8'hC9, 4, 0, 1));
    apply("mix_right", mk(1,0,0,0,1,1,0, 8'h00, 8'h64, 5, 0, 0));

    // Asynchronous clear mid-cycle while holding 5A mid-shift.
    apply("load_5a",   mk(1,0,0,1,0,0,0, 8'h5A, 8'h5A, 0, 0, 0));
    apply("pre_rst",   mk(1,0,0,0,1,0,1, 8'h00, 8'hB5, 1, 0, 1));
    @(negedge clk);
    clrn = 1'b0; #1;
    check("async_clear", 8'h00, 0, 1'b0, 1'b0);
    @(posedge clk); #1;
    check("clear_held_edge", 8'h00, 0, 1'b0, 1'b0);
    @(negedge clk);
    clrn = 1'b1;
    apply("post_rst", mk(1,0,0,0,1,0,1, 8'h00, 8'h01, 1, 0, 0));

    if (sb.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL scoreboard_drain: got %0d entries, want 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got no finish, want finish before 20000");
    $fatal(1, "timeout");
  end

endmodule
